regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between NUM_REQ writeback requesters (ALU, load, mul/CSR).
//  Arbitration is round-robin, with a valid/ready handshake per requester; the granted write is registered onto the write port.
//  Holds a busy-bit scoreboard of registers that have an in-flight writer; the issue stage queries it to stall on RAW/WAW hazards.
//  Sits between the writeback sources and the register file. The register file writes on negedge clk.
// PARAMETERS
//  NUM_REQ  3   number of writeback requesters (2..8)
//  DATA_W   32  write data width
//  ADDR_W   5   register address width (2**ADDR_W registers)
// PORTS
//  clk         in   1               system clock, posedge
//  rst         in   1               reset, asynchronous, active-high
//  req_valid   in   NUM_REQ         requester i has a write pending
//  req_ready   out  NUM_REQ         one-hot grant; transfer = valid[i] & ready[i]
//  req_addr    in   NUM_REQ*ADDR_W  dest reg of requester i, slice [i*ADDR_W +: ADDR_W]
//  req_data    in   NUM_REQ*DATA_W  write data of requester i, slice [i*DATA_W +: DATA_W]
//  rf_we       out  1               register file write enable
//  rf_waddr    out  ADDR_W          register file write address
//  rf_wdata    out  DATA_W          register file write data
//  alloc_valid in   1               issue stage marks alloc_addr as pending
//  alloc_addr  in   ADDR_W          destination being allocated
//  rs1_addr    in   ADDR_W          busy query, source 1
//  rs2_addr    in   ADDR_W          busy query, source 2
//  rd_addr     in   ADDR_W          busy query, destination (WAW check)
//  rs1_busy    out  1               busy[rs1_addr], combinational
//  rs2_busy    out  1               busy[rs2_addr], combinational
//  rd_busy     out  1               busy[rd_addr], combinational
// BEHAVIOUR
//  Reset (async, immediate): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, rr_ptr=0.
//   An in-flight write is dropped; req_ready is then derived from req_valid and rr_ptr=0.
//  Grant is combinational: scan from rr_ptr upward, modulo NUM_REQ. The first i with req_valid[i] gets req_ready[i]=1.
//   All other bits are 0, and req_ready is all 0 when no request is valid. req_ready never asserts without req_valid.
//  On transfer by i: rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds.
//  Output stage, on every posedge:
//   rf_we    <= transfer && (addr != 0)
//   rf_waddr <= granted addr
//   rf_wdata <= granted data
//   The register file commits on the following negedge.
//   Latency from accept to data readable by a posedge sampler in the next cycle is 1 cycle.
//  Writes to x0 are accepted (ready=1) but never drive rf_we.
//  Without a transfer: rf_we<=0, while rf_waddr/rf_wdata hold their values.
//  Throughput: one write per cycle. A requester holds valid, addr and data stable until it is accepted.
//  Scoreboard:
//   busy[k] set at posedge when alloc_valid && alloc_addr==k && k!=0.
//   busy[k] cleared at posedge when a transfer with addr k is accepted.
//   Simultaneous set and clear of the same k: set wins, because the new writer is still pending.
//   busy[0] is constant 0. Re-allocating an address that is already busy leaves it at 1 (no counting).
//   Issue must stall while rd_busy=1.
//  Queries read the current busy vector, with no internal bypass. A register cleared at edge N reads not-busy after edge N.
//   The data of that write is in the register file by the negedge of that same cycle.
// CONFIGURATION
//  RF_ARB_FIXED_PRIO_EN defined:
//   Fixed priority replaces round-robin: the lowest index wins, rr_ptr is removed, and req_ready[0]=req_valid[0].
//   A continuously-valid requester 0 starves the others; this is acceptable only for a single-cycle ALU source.
//  RF_ARB_FIXED_PRIO_EN undefined (default): round-robin as above, which guarantees service within NUM_REQ cycles.
// TESTING
//  1. Reset, then assert req_valid=3'b111 with addrs 1,2,3 and data A,B,C held for 3 cycles.
//     Expect grants in order 0,1,2; rf_we=1 for 3 cycles; waddr 1,2,3 with data A,B,C, each 1 cycle after accept.
//  2. Keep req0 and req2 continuously valid for 4 cycles.
//     Expect grants alternating 0,2,0,2, with requester 1 never granted.
//     With RF_ARB_FIXED_PRIO_EN, expect req0 granted every cycle.
//  3. alloc x5, then query rs1=5.
//     Expect rs1_busy=1 until requester 1 writes x5=0xDEADBEEF, then 0 on the next cycle.
//     The register file reads 0xDEADBEEF at the next posedge.
//  4. In the same cycle, alloc x7 and accept a write to x7.
//     Expect busy[7]=1 afterwards, and rf_we=1 with waddr=7.
//  5. Request a write to x0 with data 0xFFFFFFFF.
//     Expect req_ready=1 and rf_we=0. Alloc x0 -> rd_busy stays 0.
//  6. Assert rst mid-burst while busy=x3|x9 and rf_we=1.
//     Expect rf_we, busy and rr_ptr cleared immediately.
//     After release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback arbiter for the register-file write port with busy scoreboard
// Optional build macro: RF_ARB_FIXED_PRIO_EN (fixed lowest-index priority instead of round-robin)
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           rf_waddr,
   output logic [DATA_W-1:0]           rf_wdata,
   input  logic                        alloc_valid,
   input  logic [ADDR_W-1:0]           alloc_addr,
   input  logic [ADDR_W-1:0]           rs1_addr,
   input  logic [ADDR_W-1:0]           rs2_addr,
   input  logic [ADDR_W-1:0]           rd_addr,
   output logic                        rs1_busy,
   output logic                        rs2_busy,
   output logic                        rd_busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int NREG  = 1 << ADDR_W;

   logic                xfer;
   logic [ADDR_W-1:0]   gnt_addr;
   logic [DATA_W-1:0]   gnt_data;
   logic [NREG-1:0]     busy;
   logic [NREG-1:0]     busy_nxt;

`ifdef RF_ARB_FIXED_PRIO_EN
   logic found;

   always_comb begin
      req_ready = '0;
      found     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[k]) begin
            found        = 1'b1;
            req_ready[k] = 1'b1;
         end
      end
   end
`else
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] gnt_idx;
   logic             found;
   int               scan_idx;

   // Scan starts at rr_ptr and wraps, so the last winner has lowest priority next time
   always_comb begin
      req_ready = '0;
      gnt_idx   = '0;
      found     = 1'b0;
      scan_idx  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NUM_REQ)
            scan_idx = scan_idx - NUM_REQ;
         if (!found && req_valid[scan_idx]) begin
            found               = 1'b1;
            gnt_idx             = IDX_W'(scan_idx);
            req_ready[scan_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (xfer)
         rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   end
`endif

   always_comb begin
      gnt_addr = '0;
      gnt_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (req_ready[k]) begin
            gnt_addr = req_addr[k*ADDR_W +: ADDR_W];
            gnt_data = req_data[k*DATA_W +: DATA_W];
         end
      end
   end

   assign xfer = |(req_valid & req_ready);

   // x0 writes are accepted so the requester retires, but never reach the register file
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= xfer && (gnt_addr != '0);
         if (xfer) begin
            rf_waddr <= gnt_addr;
            rf_wdata <= gnt_data;
         end
      end
   end

   // Set is applied after clear so a fresh allocation survives a same-cycle writeback
   always_comb begin
      busy_nxt = busy;
      if (xfer)
         busy_nxt[gnt_addr] = 1'b0;
      if (alloc_valid)
         busy_nxt[alloc_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   assign rs1_busy = busy[rs1_addr];
   assign rs2_busy = busy[rs2_addr];
   assign rd_busy  = busy[rd_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        alloc_valid;
   logic [4:0]  alloc_addr;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        rd_busy;

   int compared;
   int mismatched;

   regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .alloc_valid (alloc_valid),
      .alloc_addr  (alloc_addr),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rd_addr     (rd_addr),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .rd_busy     (rd_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 3'b000; req_addr = '0; req_data = '0;
      alloc_valid = 1'b0; alloc_addr = '0;
      rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
      step();
      step();
      compared++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
         mismatched++;
         $display("FAIL reset_out: got we=%b waddr=%0d wdata=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
      end
      compared++;
      if (req_ready !== 3'b000) begin
         mismatched++;
         $display("FAIL reset_ready_idle: got %b want 000", req_ready);
      end
      req_valid = 3'b110;
      #1;
      compared++;
      if (req_ready !== 3'b010) begin
         mismatched++;
         $display("FAIL reset_ready_ptr0: got %b want 010", req_ready);
      end
      req_valid = 3'b000;
      #1;
      rst = 1'b0;
      step();
   endtask

   task automatic test_round_robin();
      logic [2:0]  exp_rdy [3];
      logic [2:0]  vld     [3];
      logic [31:0] dat     [3];
      vld[0] = 3'b111; vld[1] = 3'b110; vld[2] = 3'b100;
      exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100;
      dat[0] = 32'hAAAA_0001; dat[1] = 32'hBBBB_0002; dat[2] = 32'hCCCC_0003;
      req_addr = {5'd3, 5'd2, 5'd1};
      req_data = {dat[2], dat[1], dat[0]};
      for (int i = 0; i < 3; i++) begin
         req_valid = vld[i];
         #1;
         compared++;
         if (req_ready !== exp_rdy[i]) begin
            mismatched++;
            $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, exp_rdy[i]);
         end
         step();
         compared++;
         if (rf_we !== 1'b1 || rf_waddr !== 5'(i + 1) || rf_wdata !== dat[i]) begin
            mismatched++;
            $display("FAIL rr_write%0d: got we=%b waddr=%0d wdata=%h want 1/%0d/%h",
                     i, rf_we, rf_waddr, rf_wdata, i + 1, dat[i]);
         end
      end
      req_valid = 3'b000;
      step();
      compared++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd3 || rf_wdata !== 32'hCCCC_0003) begin
         mismatched++;
         $display("FAIL rr_idle_hold: got we=%b waddr=%0d wdata=%h want 0/3/cccc0003", rf_we, rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_alternate();
      logic [2:0] exp_rdy [4];
`ifdef RF_ARB_FIXED_PRIO_EN
      exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b001; exp_rdy[2] = 3'b001; exp_rdy[3] = 3'b001;
`else
      exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b100; exp_rdy[2] = 3'b001; exp_rdy[3] = 3'b100;
`endif
      req_addr = {5'd12, 5'd11, 5'd10};
      req_data = {32'h0000_0C0C, 32'h0000_0B0B, 32'h0000_0A0A};
      req_valid = 3'b101;
      for (int i = 0; i < 4; i++) begin
         #1;
         compared++;
         if (req_ready !== exp_rdy[i]) begin
            mismatched++;
            $display("FAIL alt_grant%0d: got %b want %b", i, req_ready, exp_rdy[i]);
         end
         step();
      end
      req_valid = 3'b000;
      step();
   endtask

   task automatic test_scoreboard_clear();
      rs1_addr = 5'd5;
      alloc_valid = 1'b1; alloc_addr = 5'd5;
      #1;
      compared++;
      if (rs1_busy !== 1'b0) begin
         mismatched++;
         $display("FAIL sb_pre_alloc: got %b want 0", rs1_busy);
      end
      step();
      alloc_valid = 1'b0;
      step();
      compared++;
      if (rs1_busy !== 1'b1) begin
         mismatched++;
         $display("FAIL sb_busy: got %b want 1", rs1_busy);
      end
      req_addr = {5'd0, 5'd5, 5'd0};
      req_data = {32'd0, 32'hDEAD_BEEF, 32'd0};
      req_valid = 3'b010;
      #1;
      compared++;
      if (req_ready !== 3'b010 || rs1_busy !== 1'b1) begin
         mismatched++;
         $display("FAIL sb_accept: got ready=%b busy=%b want 010/1", req_ready, rs1_busy);
      end
      step();
      req_valid = 3'b000;
      compared++;
      if (rs1_busy !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
         mismatched++;
         $display("FAIL sb_cleared: got busy=%b we=%b waddr=%0d wdata=%h want 0/1/5/deadbeef",
                  rs1_busy, rf_we, rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_set_wins();
      rd_addr = 5'd7;
      alloc_valid = 1'b1; alloc_addr = 5'd7;
      req_addr = {5'd7, 5'd0, 5'd7};
      req_data = {32'h7777_0002, 32'd0, 32'h7777_0001};
      req_valid = 3'b001;
      step();
      alloc_valid = 1'b0;
      req_valid = 3'b000;
      compared++;
      if (rd_busy !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
         mismatched++;
         $display("FAIL set_wins: got busy=%b we=%b waddr=%0d want 1/1/7", rd_busy, rf_we, rf_waddr);
      end
      req_valid = 3'b100;
      step();
      req_valid = 3'b000;
      compared++;
      if (rd_busy !== 1'b0 || rf_wdata !== 32'h7777_0002) begin
         mismatched++;
         $display("FAIL later_clear: got busy=%b wdata=%h want 0/77770002", rd_busy, rf_wdata);
      end
   endtask

   task automatic test_x0();
      rd_addr = 5'd0;
      alloc_valid = 1'b1; alloc_addr = 5'd0;
      req_addr = {5'd0, 5'd0, 5'd0};
      req_data = {32'hFFFF_FFFF, 32'd0, 32'd0};
      req_valid = 3'b100;
      #1;
      compared++;
      if (req_ready !== 3'b100) begin
         mismatched++;
         $display("FAIL x0_ready: got %b want 100", req_ready);
      end
      step();
      alloc_valid = 1'b0;
      req_valid = 3'b000;
      compared++;
      if (rf_we !== 1'b0 || rd_busy !== 1'b0) begin
         mismatched++;
         $display("FAIL x0_nowrite: got we=%b busy=%b want 0/0", rf_we, rd_busy);
      end
   endtask

   task automatic test_reset_mid_burst();
      rs1_addr = 5'd3; rs2_addr = 5'd9;
      alloc_valid = 1'b1; alloc_addr = 5'd3;
      step();
      alloc_addr = 5'd9;
      step();
      alloc_valid = 1'b0;
      req_addr = {5'd8, 5'd6, 5'd4};
      req_data = {32'h0000_0008, 32'h0000_0006, 32'h0000_0004};
      req_valid = 3'b111;
      step();
      req_valid = 3'b101;
      #1;
      compared++;
      if (rf_we !== 1'b1 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
         mismatched++;
         $display("FAIL pre_rst: got we=%b b3=%b b9=%b want 1/1/1", rf_we, rs1_busy, rs2_busy);
      end
`ifdef RF_ARB_FIXED_PRIO_EN
      compared++;
      if (req_ready !== 3'b001) begin
         mismatched++;
         $display("FAIL pre_rst_ready: got %b want 001", req_ready);
      end
`else
      compared++;
      if (req_ready !== 3'b100) begin
         mismatched++;
         $display("FAIL pre_rst_ready: got %b want 100", req_ready);
      end
`endif
      #1;
      rst = 1'b1;
      #1;
      compared++;
      if (rf_we !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || req_ready !== 3'b001) begin
         mismatched++;
         $display("FAIL async_rst: got we=%b b3=%b b9=%b ready=%b want 0/0/0/001",
                  rf_we, rs1_busy, rs2_busy, req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      req_valid = 3'b000;
      compared++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h0000_0004) begin
         mismatched++;
         $display("FAIL post_rst_grant: got we=%b waddr=%0d wdata=%h want 1/4/00000004", rf_we, rf_waddr, rf_wdata);
      end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      test_reset();
      test_round_robin();
      test_alternate();
      test_scoreboard_clear();
      test_set_wins();
      test_x0();
      test_reset_mid_burst();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
